// File: rtl/ysyx_22041412_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC, FSM encodings,
// and the PC alignment mask applied to redirect targets.
package ysyx_22041412_ifu_pkg;

    localparam logic [63:0] IFU_RESET_PC  = 64'h0000_0000_8000_0000;
    localparam int          IFU_INSTR_W   = 32;
    localparam logic [63:0] PC_ALIGN_MASK = ~64'd3;
    localparam logic [63:0] PC_STEP       = 64'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/ysyx_22041412_ifu_buf.sv
// Single-entry fetch buffer holding one instruction and its PC for decode.
// Flush drops the entry but keeps the stale payload; reset clears everything.
module ysyx_22041412_if_buf #(
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               pop,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [63:0]        load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [63:0]        pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: one outstanding memory request at a time, REQ -> WAIT -> HOLD,
// with redirects from execute overriding everything and squashing in-flight responses.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// imem_req_valid/addr and id_valid/instr/pc are held stable until that edge unless a
// redirect or reset intervenes.
module ysyx_22041412_ifu
    import ysyx_22041412_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IFU_RESET_PC,
    parameter int          INSTR_W  = IFU_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [63:0]        imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect_valid,
    input  logic [63:0]        redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [63:0]        id_pc,
    output logic [1:0]         fsm_state
);

    ifu_state_t  state, state_next;
    logic        drop, drop_next;
    logic [63:0] pc, pc_next;
    logic        buf_load, buf_pop, buf_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
            drop  <= 1'b0;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            drop  <= drop_next;
            pc    <= pc_next;
        end
    end

    // drop marks a request already accepted by memory whose response must be discarded.
    always_comb begin
        state_next = state;
        drop_next  = drop;
        pc_next    = pc;
        buf_load   = 1'b0;
        buf_pop    = 1'b0;
        buf_flush  = 1'b0;
        if (redirect_valid) begin
            pc_next   = redirect_pc & PC_ALIGN_MASK;
            buf_flush = 1'b1;
            drop_next = 1'b0;
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_next = S_WAIT;
                        drop_next  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) state_next = S_REQ;
                    else                 drop_next  = 1'b1;
                end
                default: state_next = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop) begin
                            drop_next  = 1'b0;
                            state_next = S_REQ;
                        end else begin
                            buf_load   = 1'b1;
                            pc_next    = pc + PC_STEP;
                            state_next = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (id_ready) begin
                        buf_pop    = 1'b1;
                        state_next = S_REQ;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end
    end

    always_comb begin
        imem_req_valid = (state == S_REQ);
        fsm_state      = state;
    end

    assign imem_req_addr = pc;

    ysyx_22041412_if_buf #(
        .INSTR_W (INSTR_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .pop        (buf_pop),
        .flush      (buf_flush),
        .load_instr (imem_resp_data),
        .load_pc    (pc),
        .valid      (id_valid),
        .instr      (id_instr),
        .pc         (id_pc)
    );

endmodule

// File: tb/tb_ysyx_22041412_ifu.sv
// Directed bench for the fetch unit: inputs change on the falling edge, outputs are
// checked on the falling edge, expected values are written out by hand.
module tb_ysyx_22041412_ifu;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic [1:0]  fsm_state;

    int checks   = 0;
    int failures = 0;

    ysyx_22041412_ifu #(
        .RESET_PC (64'h0000_0000_8000_0000),
        .INSTR_W  (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .fsm_state       (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
        checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL reset_id_instr: got %h expected 0", id_instr); end
        checks++; if (id_pc !== 64'h0) begin failures++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
        checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
            failures++; $display("FAIL reset_first_req: got valid=%b addr=%h expected valid=1 addr=80000000", imem_req_valid, imem_req_addr);
        end
    endtask

    // Memory always ready, response one cycle after acceptance, decode always ready.
    task automatic test_fetch_stream();
        logic [31:0] words [3];
        logic [63:0] addrs [3];
        words = '{32'h0000_0413, 32'h0010_0093, 32'h0020_8133};
        addrs = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008};
        for (int k = 0; k < 3; k++) begin
            checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== addrs[k]) begin
                failures++; $display("FAIL stream_req_%0d: got valid=%b addr=%h expected valid=1 addr=%h", k, imem_req_valid, imem_req_addr, addrs[k]);
            end
            imem_req_ready = 1'b1;
            @(negedge clk);
            checks++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
                failures++; $display("FAIL stream_wait_%0d: got req_valid=%b id_valid=%b expected 0 0", k, imem_req_valid, id_valid);
            end
            imem_req_ready = 1'b0;
            imem_resp_valid = 1'b1;
            imem_resp_data = words[k];
            @(negedge clk);
            checks++; if (id_valid !== 1'b1 || id_instr !== words[k] || id_pc !== addrs[k]) begin
                failures++; $display("FAIL stream_id_%0d: got v=%b instr=%h pc=%h expected v=1 instr=%h pc=%h", k, id_valid, id_instr, id_pc, words[k], addrs[k]);
            end
            imem_resp_valid = 1'b0;
            id_ready = 1'b1;
            @(negedge clk);
            id_ready = 1'b0;
        end
        checks++; if (id_valid !== 1'b0 || imem_req_addr !== 64'h8000_000C) begin
            failures++; $display("FAIL stream_after: got id_valid=%b addr=%h expected 0 8000000c", id_valid, imem_req_addr);
        end
    endtask

    // Decode stalls five cycles while an instruction is buffered.
    task automatic test_hold_stall();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (id_valid !== 1'b1 || id_instr !== 32'hDEAD_BEEF || id_pc !== 64'h8000_000C || imem_req_valid !== 1'b0) begin
                failures++; $display("FAIL hold_stable_%0d: got v=%b instr=%h pc=%h req=%b expected 1 deadbeef 8000000c 0", i, id_valid, id_instr, id_pc, imem_req_valid);
            end
            @(negedge clk);
        end
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0010) begin
            failures++; $display("FAIL hold_release: got v=%b req=%b addr=%h expected 0 1 80000010", id_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    // Redirect in WAIT, response lands three cycles later and must be dropped.
    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_1002;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
                failures++; $display("FAIL redir_wait_idle_%0d: got req=%b id_valid=%b expected 0 0", i, imem_req_valid, id_valid);
            end
            @(negedge clk);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_1000) begin
            failures++; $display("FAIL redir_wait_drop: got v=%b req=%b addr=%h expected 0 1 80001000", id_valid, imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h0000_0013;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        checks++; if (id_valid !== 1'b1 || id_instr !== 32'h0000_0013 || id_pc !== 64'h8000_1000) begin
            failures++; $display("FAIL redir_wait_next: got v=%b instr=%h pc=%h expected 1 00000013 80001000", id_valid, id_instr, id_pc);
        end
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
    endtask

    // Redirect coinciding with the response; stray responses in REQ are ignored.
    task automatic test_redirect_with_resp();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h1111_2222;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_2000;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_2000) begin
            failures++; $display("FAIL redir_resp: got v=%b req=%b addr=%h expected 0 1 80002000", id_valid, imem_req_valid, imem_req_addr);
        end
        id_ready = 1'b1;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        id_ready = 1'b0;
        checks++; if (id_valid !== 1'b0 || fsm_state !== 2'd0 || imem_req_addr !== 64'h8000_2000) begin
            failures++; $display("FAIL stray_resp_ignored: got v=%b state=%0d addr=%h expected 0 0 80002000", id_valid, fsm_state, imem_req_addr);
        end
    endtask

    // Redirect while holding wins over a simultaneous decode pop.
    task automatic test_redirect_hold();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h3333_4444;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8000_2000) begin
            failures++; $display("FAIL redir_hold_pre: got v=%b pc=%h expected 1 80002000", id_valid, id_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_3000;
        id_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_3000) begin
            failures++; $display("FAIL redir_hold: got v=%b req=%b addr=%h expected 0 1 80003000", id_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    // Redirect in REQ without ready, then PC+4 wraps past the top of the address space.
    task automatic test_pc_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (fsm_state !== 2'd0 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            failures++; $display("FAIL wrap_redir_req: got state=%0d addr=%h expected 0 fffffffffffffffc", fsm_state, imem_req_addr);
        end
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            failures++; $display("FAIL wrap_addr_stable: got req=%b addr=%h expected 1 fffffffffffffffc", imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h5555_6666;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        checks++; if (id_valid !== 1'b1 || id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || id_instr !== 32'h5555_6666) begin
            failures++; $display("FAIL wrap_id: got v=%b pc=%h instr=%h expected 1 fffffffffffffffc 55556666", id_valid, id_pc, id_instr);
        end
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
            failures++; $display("FAIL wrap_next_addr: got req=%b addr=%h expected 1 0", imem_req_valid, imem_req_addr);
        end
    endtask

    // Reset while a request is outstanding; its late response must not reach decode.
    task automatic test_reset_in_wait();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (fsm_state !== 2'd0 || id_valid !== 1'b0 || imem_req_addr !== 64'h8000_0000) begin
            failures++; $display("FAIL rst_wait: got state=%0d v=%b addr=%h expected 0 0 80000000", fsm_state, id_valid, imem_req_addr);
        end
        rst = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h7777_8888;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        checks++; if (id_valid !== 1'b0 || fsm_state !== 2'd0) begin
            failures++; $display("FAIL rst_late_resp: got v=%b state=%0d expected 0 0", id_valid, fsm_state);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'h0000_0297;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8000_0000 || id_instr !== 32'h0000_0297) begin
            failures++; $display("FAIL rst_next_fetch: got v=%b pc=%h instr=%h expected 1 80000000 00000297", id_valid, id_pc, id_instr);
        end
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_stream();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_with_resp();
        test_redirect_hold();
        test_pc_wrap();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
